ssd_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display.
- Owns the refresh timebase, digit rotation, hex-to-segment decode, inter-digit ghost blanking and tear-free value update.
- Sits between the application logic, which supplies a packed hex value plus masks, and the AN/SEG/DP pins.
- Replaces ad hoc free-running divided clocks: everything runs on the single system clock, with internal clock enables.

---
 rtl/ssd_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - 8-digit common-anode seven-segment scan controller with frame-aligned value update.
// Optional leading-zero suppression: define SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    load_i,
    output logic                    pending_o,
    output logic                    frame_done_o,
    output logic [7:0]              an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    logic [CNT_W-1:0]        cnt;
    logic [2:0]              idx;
    logic                    slot_end;
    logic                    frame_end;
    logic                    in_blank;
    phase_t                  phase;

    logic [4*NUM_DIGITS-1:0] pend_val, act_val;
    logic [NUM_DIGITS-1:0]   pend_en, act_en;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   lz_run;

    logic [3:0]              cur_nib;
    logic                    cur_en;
    logic                    cur_dp;
    logic                    cur_sup;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
            assign in_blank = (cnt < BLANK_END);
        end else begin : g_no_blank
            assign in_blank = 1'b0;
        end
    endgenerate

    assign phase = in_blank ? PH_BLANK : PH_SHOW;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Active data only changes at the frame boundary; a load on that same edge stays pending.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pend_val     <= '0;
            pend_en      <= '0;
            pend_dp      <= '0;
            act_val      <= '0;
            act_en       <= '0;
            act_dp       <= '0;
            pending_o    <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= frame_end;
            if (frame_end && pending_o) begin
                act_val <= pend_val;
                act_en  <= pend_en;
                act_dp  <= pend_dp;
            end
            if (load_i) begin
                pend_val  <= value_i;
                pend_en   <= digit_en_i;
                pend_dp   <= dp_i;
                pending_o <= 1'b1;
            end else if (frame_end) begin
                pending_o <= 1'b0;
            end
        end
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Suppression run starts at the top digit and breaks at the first nonzero enabled nibble or lit dp.
    always_comb begin
        logic run;
        run    = 1'b1;
        lz_run = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run       = run && ((act_val[i*4 +: 4] == 4'h0) || !act_en[i]) && !act_dp[i];
            lz_run[i] = run;
        end
        lz_run[0] = 1'b0;
    end
`else
    assign lz_run = '0;
`endif

    always_comb begin
        cur_nib = 4'h0;
        cur_en  = 1'b0;
        cur_dp  = 1'b0;
        cur_sup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                cur_nib = act_val[i*4 +: 4];
                cur_en  = act_en[i];
                cur_dp  = act_dp[i];
                cur_sup = lz_run[i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            an_o  <= 8'hFF;
            seg_o <= 7'h7F;
            dp_o  <= 1'b1;
        end else if (phase == PH_SHOW && cur_en && !cur_sup) begin
            an_o  <= ~(8'h01 << idx);
            seg_o <= seg_decode(cur_nib);
            dp_o  <= ~cur_dp;
        end else begin
            an_o  <= 8'hFF;
            seg_o <= 7'h7F;
            dp_o  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - directed self-checking bench for ssd_scan_ctrl (4 digits, 10-cycle slots, 2 blank).
module tb_ssd_scan_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] value_i = '0;
    logic [3:0]  digit_en_i = '0;
    logic [3:0]  dp_i = '0;
    logic        load_i = 1'b0;
    logic        pending_o;
    logic        frame_done_o;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    ssd_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(10), .BLANK_CYCLES(2)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .value_i      (value_i),
        .digit_en_i   (digit_en_i),
        .dp_i         (dp_i),
        .load_i       (load_i),
        .pending_o    (pending_o),
        .frame_done_o (frame_done_o),
        .an_o         (an_o),
        .seg_o        (seg_o),
        .dp_o         (dp_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        k++;
    endtask

    // Runs one full 40-cycle frame starting just after a boundary edge; loads fire at offsets la/lb.
    task automatic run_frame(input string tag, input logic [15:0] ev, input logic [3:0] evis,
                             input logic [3:0] edp, input bit pin,
                             input int la, input logic [15:0] va, input int lb, input logic [15:0] vb,
                             input logic [3:0] len, input logic [3:0] ldp);
        int s, c;
        logic [7:0] ean;
        logic [6:0] eseg;
        logic       edpo;
        bit         pend38;
        pend38 = pin || (la >= 0 && la < 39) || (lb >= 0 && lb < 39);
        for (int o = 0; o < 40; o++) begin
            load_i     = (o == la) || (o == lb);
            value_i    = (o == lb) ? vb : va;
            digit_en_i = len;
            dp_i       = ldp;
            step();
            load_i = 1'b0;
            s = o / 10;
            c = o % 10;
            ean  = 8'hFF;
            eseg = 7'h7F;
            edpo = 1'b1;
            if (c >= 2 && evis[s]) begin
                ean  = ~(8'h01 << s);
                eseg = SEG[ev[s*4 +: 4]];
                edpo = ~edp[s];
            end
            check($sformatf("%s.an@%0d", tag, o), 32'(an_o), 32'(ean));
            check($sformatf("%s.seg@%0d", tag, o), 32'(seg_o), 32'(eseg));
            check($sformatf("%s.dp@%0d", tag, o), 32'(dp_o), 32'(edpo));
            if (o == 19) check($sformatf("%s.fd_mid", tag), 32'(frame_done_o), 32'd0);
            if (o == 38) check($sformatf("%s.pend38", tag), 32'(pending_o), 32'(pend38));
            if (o == 39) begin
                check($sformatf("%s.fd_end", tag), 32'(frame_done_o), 32'd1);
                check($sformatf("%s.pend_end", tag), 32'(pending_o), 32'((la == 39) || (lb == 39)));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("rst.an", 32'(an_o), 32'hFF);
        check("rst.seg", 32'(seg_o), 32'h7F);
        check("rst.dp", 32'(dp_o), 32'd1);
        check("rst.pend", 32'(pending_o), 32'd0);
        check("rst.fd", 32'(frame_done_o), 32'd0);
        rst_n = 1'b1;
        k = 0;

        for (int i = 1; i <= 80; i++) begin
            step();
            check($sformatf("idle.an@%0d", k), 32'(an_o), 32'hFF);
            check($sformatf("idle.seg@%0d", k), 32'(seg_o), 32'h7F);
            check($sformatf("idle.fd@%0d", k), 32'(frame_done_o), 32'((k % 40) == 0));
        end

        run_frame("f1", 16'h0000, 4'h0, 4'h0, 1'b0, 0, 16'h12AF, -1, 16'h0, 4'hF, 4'h0);
        run_frame("f2", 16'h12AF, 4'hF, 4'h0, 1'b0, 5, 16'h1111, 20, 16'h2222, 4'hF, 4'h0);
        run_frame("f3", 16'h2222, 4'hF, 4'h0, 1'b0, 10, 16'h4444, 39, 16'h9B7C, 4'b0101, 4'b0001);
        run_frame("f4", 16'h4444, 4'b0101, 4'b0001, 1'b1, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);
        run_frame("f5", 16'h9B7C, 4'b0101, 4'b0001, 1'b0, 0, 16'h0050, -1, 16'h0, 4'hF, 4'h0);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        run_frame("f6", 16'h0050, 4'b0011, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);
`else
        run_frame("f6", 16'h0050, 4'hF, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);
`endif

        repeat (3) step();
        value_i    = 16'h8888;
        digit_en_i = 4'hF;
        dp_i       = 4'h0;
        load_i     = 1'b1;
        step();
        load_i = 1'b0;
        repeat (5) step();
        check("mid.pend_pre", 32'(pending_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.an", 32'(an_o), 32'hFF);
        check("mid.seg", 32'(seg_o), 32'h7F);
        check("mid.dp", 32'(dp_o), 32'd1);
        check("mid.pend", 32'(pending_o), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        run_frame("r1", 16'h0000, 4'h0, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);
        run_frame("r2", 16'h0000, 4'h0, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
